os_tx_scheduler: RTL and testbench

//  Sequences the per-lane PIPE TX datapath by choosing, each cycle, what the framer drives:

---
 rtl/os_sched_pkg.sv | 32 +++
 rtl/skp_interval_timer.sv | 43 ++++
 rtl/os_tx_scheduler.sv | 152 +++++++++++++++
 tb/tb_os_tx_scheduler.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/os_sched_pkg.sv
// Shared encodings for the TX ordered-set scheduler: framer select codes,
// ordered-set types, scheduler state type and gen3 symbol constants.
package os_sched_pkg;

    localparam logic [1:0] SEL_IDLE = 2'd0;
    localparam logic [1:0] SEL_DATA = 2'd1;
    localparam logic [1:0] SEL_OS   = 2'd2;
    localparam logic [1:0] SEL_SKP  = 2'd3;

    localparam logic [1:0] OS_TS1   = 2'd0;
    localparam logic [1:0] OS_TS2   = 2'd1;
    localparam logic [1:0] OS_EIOS  = 2'd2;
    localparam logic [1:0] OS_EIEOS = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_OS   = 2'd2,
        ST_SKP  = 2'd3
    } sched_state_t;

    localparam logic [7:0] SYM_COM = 8'hBC;
    localparam logic [7:0] SYM_TS1 = 8'h1E;
    localparam logic [7:0] SYM_TS2 = 8'h2D;
    localparam logic [7:0] SYM_SKP = 8'hAA;

    // A burst request of zero sets still sends one set.
    function automatic logic [7:0] burst_len(input logic [7:0] cnt);
        return (cnt == 8'd0) ? 8'd1 : cnt;
    endfunction

endpackage

// File: rtl/skp_interval_timer.sv
// SKP interval timer: free-running interval counter plus a saturating (max 3)
// count of SKP ordered sets owed to the link.
module skp_interval_timer
    import os_sched_pkg::*;
#(
    parameter int SKP_INTERVAL = 1180,
    parameter int CNT_W        = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sent_pulse,
    output logic [1:0] owed,
    output logic       pending
);

    logic [CNT_W-1:0] cnt;
    logic             wrap;

    assign wrap    = (cnt == CNT_W'(SKP_INTERVAL - 1));
    assign pending = (owed != 2'd0);

    // Interval counter runs 0..SKP_INTERVAL-1 regardless of scheduler state.
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (wrap)
            cnt <= '0;
        else
            cnt <= cnt + CNT_W'(1);
    end

    // Owed count: +1 on wrap (saturating), -1 on a completed SKP, hold if both.
    always_ff @(posedge clk) begin
        if (reset)
            owed <= 2'd0;
        else if (wrap && !sent_pulse) begin
            if (owed != 2'd3)
                owed <= owed + 2'd1;
        end else if (!wrap && sent_pulse)
            owed <= owed - 2'd1;
    end

endmodule

// File: rtl/os_tx_scheduler.sv
// Per-lane TX scheduler: picks idle / data / LTSSM ordered-set burst / SKP
// for the framer each cycle. Decisions are taken only at boundaries (idle,
// last cycle of a set, or the data_eop cycle); all outputs are registered.
// Optional build macro OS_SCHED_STATS_EN adds os_sent_cnt / skp_sent_cnt.
module os_tx_scheduler
    import os_sched_pkg::*;
#(
    parameter int SKP_INTERVAL = 1180,
    parameter int OS_CYCLES    = 4,
    parameter int CNT_W        = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        linkUp,
    input  logic        os_req,
    input  logic [1:0]  os_type,
    input  logic [7:0]  os_count,
    output logic        os_ack,
    input  logic        data_req,
    input  logic        data_eop,
    output logic        data_grant,
    output logic [1:0]  sel,
    output logic [1:0]  os_type_out,
    output logic        os_start,
    output logic        skp_pending
`ifdef OS_SCHED_STATS_EN
    ,
    output logic [15:0] os_sent_cnt,
    output logic [15:0] skp_sent_cnt
`endif
);

    localparam int CYC_W = (OS_CYCLES > 1) ? $clog2(OS_CYCLES) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST   = CYC_W'(OS_CYCLES - 1);
    localparam logic [CYC_W-1:0] CYC_PENULT = (OS_CYCLES > 1) ? CYC_W'(OS_CYCLES - 2) : '0;

    sched_state_t     state;
    logic [CYC_W-1:0] set_cyc;
    logic [7:0]       burst_cnt;   // sets left in the burst, including the current one
    logic [1:0]       cur_type;
    logic             in_burst;
    logic [1:0]       owed;

    logic       last_cyc, os_set_done, skp_done, burst_done, cont_burst, boundary;
    logic [7:0] rem_sets, new_len;
    logic [1:0] owed_avail;

    assign last_cyc    = (set_cyc == CYC_LAST);
    assign os_set_done = (state == ST_OS) && last_cyc;
    assign skp_done    = (state == ST_SKP) && last_cyc;
    assign burst_done  = os_set_done && (burst_cnt == 8'd1);
    assign cont_burst  = in_burst && !burst_done;
    assign rem_sets    = os_set_done ? (burst_cnt - 8'd1) : burst_cnt;
    // The SKP finishing now no longer counts as owed when choosing what follows it.
    assign owed_avail  = owed - {1'b0, skp_done};
    assign new_len     = burst_len(os_count);
    assign boundary    = (state == ST_IDLE) || os_set_done || skp_done ||
                         ((state == ST_DATA) && data_eop);

    skp_interval_timer #(
        .SKP_INTERVAL (SKP_INTERVAL),
        .CNT_W        (CNT_W)
    ) u_skp_timer (
        .clk        (clk),
        .reset      (reset),
        .sent_pulse (skp_done),
        .owed       (owed),
        .pending    (skp_pending)
    );

    // Scheduler FSM with registered framer controls; os_ack is looked ahead one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            set_cyc     <= '0;
            burst_cnt   <= 8'd0;
            cur_type    <= OS_TS1;
            in_burst    <= 1'b0;
            sel         <= SEL_IDLE;
            os_ack      <= 1'b0;
            os_start    <= 1'b0;
            data_grant  <= 1'b0;
            os_type_out <= 2'd0;
        end else begin
            os_start <= 1'b0;
            os_ack   <= 1'b0;
            if (os_set_done)
                burst_cnt <= rem_sets;
            if (burst_done)
                in_burst <= 1'b0;
            if (boundary) begin
                set_cyc <= '0;
                if (owed_avail != 2'd0) begin
                    state       <= ST_SKP;
                    sel         <= SEL_SKP;
                    os_start    <= 1'b1;
                    data_grant  <= 1'b0;
                    os_type_out <= 2'd0;
                end else if (cont_burst) begin
                    state       <= ST_OS;
                    sel         <= SEL_OS;
                    os_start    <= 1'b1;
                    data_grant  <= 1'b0;
                    os_type_out <= cur_type;
                    os_ack      <= (OS_CYCLES == 1) && (rem_sets == 8'd1);
                end else if (os_req) begin
                    state       <= ST_OS;
                    sel         <= SEL_OS;
                    os_start    <= 1'b1;
                    data_grant  <= 1'b0;
                    os_type_out <= os_type;
                    cur_type    <= os_type;
                    burst_cnt   <= new_len;
                    in_burst    <= 1'b1;
                    os_ack      <= (OS_CYCLES == 1) && (new_len == 8'd1);
                end else if (data_req && linkUp) begin
                    state       <= ST_DATA;
                    sel         <= SEL_DATA;
                    data_grant  <= 1'b1;
                    os_type_out <= 2'd0;
                end else begin
                    state       <= ST_IDLE;
                    sel         <= SEL_IDLE;
                    data_grant  <= 1'b0;
                    os_type_out <= 2'd0;
                end
            end else begin
                if (state != ST_DATA)
                    set_cyc <= set_cyc + CYC_W'(1);
                if ((OS_CYCLES > 1) && (state == ST_OS) && (set_cyc == CYC_PENULT) &&
                    (burst_cnt == 8'd1))
                    os_ack <= 1'b1;
            end
        end
    end

`ifdef OS_SCHED_STATS_EN
    // Completed-set statistics, wrapping at 2**16.
    always_ff @(posedge clk) begin
        if (reset) begin
            os_sent_cnt  <= 16'd0;
            skp_sent_cnt <= 16'd0;
        end else begin
            if (os_set_done)
                os_sent_cnt <= os_sent_cnt + 16'd1;
            if (skp_done)
                skp_sent_cnt <= skp_sent_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_os_tx_scheduler.sv
// Directed bench for os_tx_scheduler. Instance u_dut_a uses default timing
// (SKP_INTERVAL 1180, OS_CYCLES 4); u_dut_b uses SKP_INTERVAL 20 for the
// owed-saturation case. Cycle 0 is the first cycle after reset release;
// outputs and stimulus are handled on the falling edge.
module tb_os_tx_scheduler;
    import os_sched_pkg::*;

    localparam int LOGN = 1300;

    logic       clk = 1'b0;
    logic       reset, linkUp, os_req, data_req, data_eop;
    logic [1:0] os_type;
    logic [7:0] os_count;

    logic       os_ack_a, data_grant_a, os_start_a, skp_pending_a;
    logic [1:0] sel_a, os_type_out_a;
    logic       os_ack_b, data_grant_b, os_start_b, skp_pending_b;
    logic [1:0] sel_b, os_type_out_b;
`ifdef OS_SCHED_STATS_EN
    logic [15:0] os_sent_a, skp_sent_a, os_sent_b, skp_sent_b;
`endif

    always #5 clk = ~clk;

    os_tx_scheduler #(.SKP_INTERVAL(1180), .OS_CYCLES(4), .CNT_W(12)) u_dut_a (
        .clk(clk), .reset(reset), .linkUp(linkUp), .os_req(os_req), .os_type(os_type),
        .os_count(os_count), .os_ack(os_ack_a), .data_req(data_req), .data_eop(data_eop),
        .data_grant(data_grant_a), .sel(sel_a), .os_type_out(os_type_out_a),
        .os_start(os_start_a), .skp_pending(skp_pending_a)
`ifdef OS_SCHED_STATS_EN
        , .os_sent_cnt(os_sent_a), .skp_sent_cnt(skp_sent_a)
`endif
    );

    os_tx_scheduler #(.SKP_INTERVAL(20), .OS_CYCLES(4), .CNT_W(12)) u_dut_b (
        .clk(clk), .reset(reset), .linkUp(linkUp), .os_req(os_req), .os_type(os_type),
        .os_count(os_count), .os_ack(os_ack_b), .data_req(data_req), .data_eop(data_eop),
        .data_grant(data_grant_b), .sel(sel_b), .os_type_out(os_type_out_b),
        .os_start(os_start_b), .skp_pending(skp_pending_b)
`ifdef OS_SCHED_STATS_EN
        , .os_sent_cnt(os_sent_b), .skp_sent_cnt(skp_sent_b)
`endif
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc, grants, pkt_len, os_at_grant, os_req_cyc, data_req_cyc, link_drop_at;
    bit         use_b, keep_req;
    logic [1:0] req_type;
    logic [7:0] req_count;

    logic [1:0] sel_log   [LOGN];
    logic [1:0] type_log  [LOGN];
    logic       start_log [LOGN];
    logic       ack_log   [LOGN];
    logic       grant_log [LOGN];
    logic       pend_log  [LOGN];

    task automatic check_val(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int cnt_sel(input int lo, input int hi, input int v);
        int n = 0;
        for (int k = lo; k <= hi; k++) if (int'(sel_log[k]) == v) n++;
        return n;
    endfunction

    function automatic int cnt_start(input int lo, input int hi, input int v);
        int n = 0;
        for (int k = lo; k <= hi; k++) if (start_log[k] && int'(sel_log[k]) == v) n++;
        return n;
    endfunction

    function automatic int cnt_ack(input int lo, input int hi);
        int n = 0;
        for (int k = lo; k <= hi; k++) if (ack_log[k]) n++;
        return n;
    endfunction

    function automatic int cnt_grant(input int lo, input int hi);
        int n = 0;
        for (int k = lo; k <= hi; k++) if (grant_log[k]) n++;
        return n;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        os_req = 1'b0; data_req = 1'b0; data_eop = 1'b0; linkUp = 1'b1;
        os_type = 2'd0; os_count = 8'd0;
        pkt_len = 0; os_at_grant = 0; os_req_cyc = -1; data_req_cyc = -1;
        link_drop_at = 0; keep_req = 1'b0; grants = 0; use_b = 1'b0;
        req_type = 2'd0; req_count = 8'd0;
        for (int k = 0; k < LOGN; k++) begin
            sel_log[k] = 2'd0; type_log[k] = 2'd0; start_log[k] = 1'b0;
            ack_log[k] = 1'b0; grant_log[k] = 1'b0; pend_log[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        cyc = 0;
    endtask

    // Logs one cycle of outputs, then plays the LTSSM / link-layer side.
    task automatic run(input int n);
        logic s_ack, s_grant;
        for (int i = 0; i < n; i++) begin
            s_ack   = use_b ? os_ack_b : os_ack_a;
            s_grant = use_b ? data_grant_b : data_grant_a;
            if (cyc < LOGN) begin
                sel_log[cyc]   = use_b ? sel_b : sel_a;
                type_log[cyc]  = use_b ? os_type_out_b : os_type_out_a;
                start_log[cyc] = use_b ? os_start_b : os_start_a;
                ack_log[cyc]   = s_ack;
                grant_log[cyc] = s_grant;
                pend_log[cyc]  = use_b ? skp_pending_b : skp_pending_a;
            end
            data_eop = 1'b0;
            if (s_ack) os_req = 1'b0;
            if (cyc == os_req_cyc) begin
                os_req = 1'b1; os_type = req_type; os_count = req_count;
            end
            if (cyc == data_req_cyc) data_req = 1'b1;
            if (s_grant) begin
                grants++;
                if (grants == os_at_grant) begin
                    os_req = 1'b1; os_type = req_type; os_count = req_count;
                end
                if (grants == link_drop_at) linkUp = 1'b0;
                if (grants == pkt_len) begin
                    data_eop = 1'b1;
                    data_req = keep_req;
                end
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        // 1: reset values, then the first SKP after one idle interval
        do_reset();
        run(1191);
        check_val("rst_sel", int'(sel_log[0]), 0);
        check_val("rst_grant", int'(grant_log[0]), 0);
        check_val("rst_ack", int'(ack_log[0]), 0);
        check_val("rst_start", int'(start_log[0]), 0);
        check_val("rst_pend", int'(pend_log[0]), 0);
        check_val("rst_type", int'(type_log[0]), 0);
        check_val("idle_no_skp_early", cnt_sel(0, 1180, 3), 0);
        check_val("pend_before_wrap", int'(pend_log[1179]), 0);
        check_val("pend_after_wrap", int'(pend_log[1180]), 1);
        check_val("skp_cycles", cnt_sel(1181, 1184, 3), 4);
        check_val("skp_then_idle", int'(sel_log[1185]), 0);
        check_val("skp_start_once", cnt_start(0, 1190, 3), 1);
        check_val("pend_cleared", int'(pend_log[1185]), 0);

        // 2: TS1 burst of 16 from idle
        do_reset();
        req_type = OS_TS1; req_count = 8'd16; os_req_cyc = 0;
        run(70);
        check_val("ts1_first_cycle", int'(sel_log[1]), 2);
        check_val("ts1_os_cycles", cnt_sel(1, 64, 2), 64);
        check_val("ts1_starts", cnt_start(0, 69, 2), 16);
        check_val("ts1_ack_cycle", int'(ack_log[64]), 1);
        check_val("ts1_ack_count", cnt_ack(0, 69), 1);
        check_val("ts1_idle_after", int'(sel_log[65]), 0);

        // 3: OS request raised mid-packet waits for data_eop
        do_reset();
        data_req_cyc = 0; pkt_len = 10;
        req_type = OS_TS2; req_count = 8'd1; os_at_grant = 3;
        run(20);
        check_val("pkt_grants", cnt_grant(0, 19), 10);
        check_val("pkt_grant_first", int'(grant_log[1]), 1);
        check_val("pkt_grant_last", int'(grant_log[10]), 1);
        check_val("pkt_sel_data", int'(sel_log[5]), 1);
        check_val("pkt_os_after_eop", int'(sel_log[11]), 2);
        check_val("pkt_os_type", int'(type_log[11]), 1);
        check_val("pkt_os_ack", int'(ack_log[14]), 1);

        // 4: interval wraps during a TS2 burst of 4
        do_reset();
        req_type = OS_TS2; req_count = 8'd4; os_req_cyc = 1173;
        run(1200);
        check_val("mid_first_two_sets", cnt_sel(1174, 1181, 2), 8);
        check_val("mid_skp_inserted", cnt_sel(1182, 1185, 3), 4);
        check_val("mid_resume_sel", int'(sel_log[1186]), 2);
        check_val("mid_resume_type", int'(type_log[1186]), 1);
        check_val("mid_total_os", cnt_sel(1174, 1199, 2), 16);
        check_val("mid_os_starts", cnt_start(1170, 1199, 2), 4);
        check_val("mid_ack_cycle", int'(ack_log[1193]), 1);
        check_val("mid_ack_count", cnt_ack(1170, 1199), 1);
        check_val("mid_idle_after", int'(sel_log[1194]), 0);

        // 5: long packet over 4 intervals of 20 -> owed saturates at 3
        do_reset();
        use_b = 1'b1;
        data_req_cyc = 0; pkt_len = 85;
        run(100);
        check_val("sat_grants", cnt_grant(0, 99), 85);
        check_val("sat_pend_in_pkt", int'(pend_log[85]), 1);
        check_val("sat_skp_cycles", cnt_sel(86, 97, 3), 12);
        check_val("sat_skp_starts", cnt_start(86, 97, 3), 3);
        check_val("sat_pend_last", int'(pend_log[97]), 1);
        check_val("sat_idle_after", int'(sel_log[98]), 0);
        check_val("sat_pend_clear", int'(pend_log[98]), 0);

        // 6: reset mid-burst, then a zero-count request sends one set
        do_reset();
        req_type = OS_EIEOS; req_count = 8'd8; os_req_cyc = 0;
        run(11);
        check_val("abort_mid_burst", int'(sel_log[10]), 2);
        check_val("abort_no_ack_before", cnt_ack(0, 10), 0);
        reset = 1'b1; os_req = 1'b0; os_req_cyc = -1;
        @(negedge clk);
        check_val("abort_sel", int'(sel_a), 0);
        check_val("abort_start", int'(os_start_a), 0);
        check_val("abort_ack", int'(os_ack_a), 0);
        check_val("abort_type", int'(os_type_out_a), 0);
        check_val("abort_grant", int'(data_grant_a), 0);
        do_reset();
        req_type = OS_EIOS; req_count = 8'd0; os_req_cyc = 0;
        run(12);
        check_val("cnt0_os_cycles", cnt_sel(0, 11, 2), 4);
        check_val("cnt0_starts", cnt_start(0, 11, 2), 1);
        check_val("cnt0_type", int'(type_log[1]), 2);
        check_val("cnt0_ack_cycle", int'(ack_log[4]), 1);
        check_val("cnt0_idle_after", int'(sel_log[5]), 0);

        // 7: linkUp drops mid-packet -> packet finishes, no new grant
        do_reset();
        data_req_cyc = 0; pkt_len = 5; link_drop_at = 2; keep_req = 1'b1;
        run(15);
        check_val("lnk_grants", cnt_grant(0, 14), 5);
        check_val("lnk_grant_last", int'(grant_log[5]), 1);
        check_val("lnk_idle_after", int'(sel_log[6]), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
